alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Control-step sequencer that sits directly upstream of the datapath and replaces the hand-driven T-state stimulus.
//  Accepts one register-to-register ALU request (op, Ra, Rb, Rc) and walks the datapath through its control steps:
//  Ra->Y, Rb+ALU->Z, Z->Rc (HI/LO for MUL/DIV).
//  It drives the one-hot bus-select (encIn), register load enables and one-hot ALU op lines.
//  It is a Moore FSM: all outputs decode from the registered state and latched request fields.
// PARAMETERS
//  ENC_W    32  width of one-hot bus-select vector
//  ZHI_BIT  18  enc_out bit that gates ZHI onto bus
//  ZLO_BIT  19  enc_out bit that gates ZLO onto bus
// PORTS
//  Clock    in   1   system clock, rising edge
//  Clear    in   1   asynchronous, active-high reset
//  start    in   1   request strobe; sampled only in IDLE
//  opcode   in   4   0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHRA,6 SHL,7 ROR,8 ROL,9 MUL,10 DIV,11 NEG,12 NOT; 13-15 illegal
//  ra       in   4   source A register index (sole source for NEG/NOT)
//  rb       in   4   source B register index
//  rc       in   4   destination register index (ignored for MUL/DIV)
//  busy     out  1   high in every non-IDLE state
//  done     out  1   high exactly during the final write step
//  err      out  1   one-cycle pulse: illegal opcode presented with start in IDLE
//  enc_out  out  ENC_W  one-hot bus select; bits 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR
//  reg_in   out  16  one-hot R0in..R15in
//  y_in     out  1   Yin
//  zhi_in   out  1   ZHIin
//  zlo_in   out  1   ZLOin
//  hi_in    out  1   HIin
//  lo_in    out  1   LOin
//  alu_ctl  out  13  one-hot ALU op; [0]NOT [1]OR [2]AND [3]SHR [4]SHRA [5]SHL [6]ADD [7]NEG [8]SUB [9]ROR [10]ROL [11]DIV [12]MUL
// BEHAVIOUR
//  Reset:
//  - Clear forces state IDLE immediately, mid-operation included; no resume.
//  - In IDLE every output is 0, and all outputs are 0 while Clear is high.
//  Accept: start=1 in IDLE with a legal opcode latches opcode/ra/rb/rc at the posedge.
//  - The next cycle is the first step.
//  - start while busy is ignored and not queued.
//  - Latched fields are stable for the whole sequence.
//  States:
//  - IDLE  -> TA (binary op) | TB (NEG/NOT) | IDLE+err (illegal).
//  - TA    : enc_out[ra]=1, y_in=1                                   -> TB
//  - TB    : enc_out[src]=1 (src=rb binary, ra unary); alu_ctl[op]=1; zlo_in=1; zhi_in=1 only for MUL/DIV
//            -> TWLO
//  - TWLO  : enc_out[ZLO_BIT]=1; reg_in[rc]=1, or lo_in=1 for MUL/DIV; done=1 unless MUL/DIV
//            -> TWHI (MUL/DIV) | IDLE
//  - TWHI  : enc_out[ZHI_BIT]=1, hi_in=1, done=1                      -> IDLE
//  Latency, in cycles from the accept edge to the done cycle inclusive:
//  - binary: 3
//  - NEG/NOT: 2
//  - MUL/DIV: 4
//  Back-to-back requests: a new start is sampled in the first IDLE cycle after done.
//  Invariants, all checkable every cycle:
//  - enc_out has at most one bit set.
//  - reg_in has at most one bit set.
//  - alu_ctl has at most one bit set.
//  - alu_ctl is non-zero only in TB.
//  Aliasing: rc==ra or rc==rb is legal; the source was already consumed before TWLO.
//  R0 is writable like any other register. DIV by zero is the datapath's concern; the sequencer does not check it.
//  err asserts in the IDLE cycle after the illegal request is sampled; busy stays 0 and no enable fires.
// TESTING
//  - ADD ra=1 rb=2 rc=3: TA enc_out=0x2,y_in; TB enc_out=0x4,alu_ctl=0x040,zlo_in; TWLO enc_out=0x80000,reg_in=0x0008,done.
//  - MUL ra=4 rb=5: TB alu_ctl=0x1000, zhi_in=zlo_in=1; TWLO lo_in=1, done=0; TWHI enc_out=0x40000, hi_in=1, done=1; busy 4 cycles.
//  - NOT ra=7 rc=7: TA skipped; TB enc_out=0x80, alu_ctl=0x001; TWLO reg_in=0x0080, done after 2 cycles.
//  - opcode=14 with start -> err=1 for one cycle, busy=0, all enables 0; following legal ADD is accepted normally.
//  - Clear pulsed during TB of a DIV -> outputs all 0 at once; no hi_in/lo_in ever asserted; IDLE after release.
//  - start held high during an SUB sequence -> second SUB begins the cycle after done; no request dropped or duplicated mid-sequence.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Moore control-step sequencer: walks one register-to-register ALU request through
// Ra->Y, Rb+ALU->Z, Z->Rc (or Z->LO/HI for MUL/DIV) on the datapath control lines.
module alu_op_sequencer #(
  parameter int ENC_W   = 32,
  parameter int ZHI_BIT = 18,
  parameter int ZLO_BIT = 19
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic [3:0]       rc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ENC_W-1:0] enc_out,
  output logic [15:0]      reg_in,
  output logic             y_in,
  output logic             zhi_in,
  output logic             zlo_in,
  output logic             hi_in,
  output logic             lo_in,
  output logic [12:0]      alu_ctl
);

  typedef enum logic [2:0] {IDLE, TA, TB, TWLO, TWHI} state_t;

  state_t     state, state_n;
  logic       err_q, err_n;
  logic       accept;
  logic [3:0] op_q, ra_q, rb_q, rc_q;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'd12;
  endfunction

  function automatic logic is_unary(input logic [3:0] op);
    return (op == 4'd11) || (op == 4'd12);
  endfunction

  function automatic logic is_wide(input logic [3:0] op);
    return (op == 4'd9) || (op == 4'd10);
  endfunction

  // Opcode numbering and ALU op-line ordering differ, so this is a lookup, not a shift.
  function automatic logic [12:0] alu_onehot(input logic [3:0] op);
    logic [12:0] v;
    v = '0;
    case (op)
      4'd0:    v[6]  = 1'b1;
      4'd1:    v[8]  = 1'b1;
      4'd2:    v[2]  = 1'b1;
      4'd3:    v[1]  = 1'b1;
      4'd4:    v[3]  = 1'b1;
      4'd5:    v[4]  = 1'b1;
      4'd6:    v[5]  = 1'b1;
      4'd7:    v[9]  = 1'b1;
      4'd8:    v[10] = 1'b1;
      4'd9:    v[12] = 1'b1;
      4'd10:   v[11] = 1'b1;
      4'd11:   v[7]  = 1'b1;
      4'd12:   v[0]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
    end
  end

  // Request fields are data only; they are qualified by state and need no reset.
  always_ff @(posedge Clock) begin
    if (accept) begin
      op_q <= opcode;
      ra_q <= ra;
      rb_q <= rb;
      rc_q <= rc;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_legal(opcode)) begin
            accept  = 1'b1;
            state_n = is_unary(opcode) ? TB : TA;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      TA:      state_n = TB;
      TB:      state_n = TWLO;
      TWLO:    state_n = is_wide(op_q) ? TWHI : IDLE;
      TWHI:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    err     = err_q;
    enc_out = '0;
    reg_in  = '0;
    y_in    = 1'b0;
    zhi_in  = 1'b0;
    zlo_in  = 1'b0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    alu_ctl = '0;
    case (state)
      TA: begin
        busy    = 1'b1;
        enc_out = ENC_W'(1) << ra_q;
        y_in    = 1'b1;
      end
      TB: begin
        busy    = 1'b1;
        enc_out = ENC_W'(1) << (is_unary(op_q) ? ra_q : rb_q);
        alu_ctl = alu_onehot(op_q);
        zlo_in  = 1'b1;
        zhi_in  = is_wide(op_q);
      end
      TWLO: begin
        busy             = 1'b1;
        enc_out[ZLO_BIT] = 1'b1;
        if (is_wide(op_q)) lo_in  = 1'b1;
        else               reg_in = 16'(1) << rc_q;
        done             = !is_wide(op_q);
      end
      TWHI: begin
        busy             = 1'b1;
        enc_out[ZHI_BIT] = 1'b1;
        hi_in            = 1'b1;
        done             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle vector table plus a Clear-abort sequence.
module tb_alu_op_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        start;
  logic [3:0]  opcode, ra, rb, rc;
  logic        busy, done, err, y_in, zhi_in, zlo_in, hi_in, lo_in;
  logic [31:0] enc_out;
  logic [15:0] reg_in;
  logic [12:0] alu_ctl;

  int checks   = 0;
  int failures = 0;

  alu_op_sequencer #(.ENC_W(32), .ZHI_BIT(18), .ZLO_BIT(19)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .err(err),
    .enc_out(enc_out), .reg_in(reg_in), .y_in(y_in), .zhi_in(zhi_in),
    .zlo_in(zlo_in), .hi_in(hi_in), .lo_in(lo_in), .alu_ctl(alu_ctl)
  );

  always #5 Clock = ~Clock;

  // flags order: {busy, done, err, y_in, zhi_in, zlo_in, hi_in, lo_in}
  localparam logic [7:0] F_IDLE = 8'b0000_0000;
  localparam logic [7:0] F_TA   = 8'b1001_0000;
  localparam logic [7:0] F_TB   = 8'b1000_0100;
  localparam logic [7:0] F_TBW  = 8'b1000_1100;
  localparam logic [7:0] F_WLO  = 8'b1100_0000;
  localparam logic [7:0] F_WLOW = 8'b1000_0001;
  localparam logic [7:0] F_WHI  = 8'b1100_0010;
  localparam logic [7:0] F_ERR  = 8'b0010_0000;

  typedef struct {
    string       name;
    logic        st;
    logic [3:0]  op, a, b, c;
    logic [68:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic s, input logic [3:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c, input logic [7:0] fl,
                     input logic [15:0] rg, input logic [12:0] al, input logic [31:0] en);
    vec_t v;
    v.name = nm; v.st = s; v.op = op; v.a = a; v.b = b; v.c = c;
    v.exp  = {fl, rg, al, en};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [68:0] exp);
    logic [68:0] act;
    act = {busy, done, err, y_in, zhi_in, zlo_in, hi_in, lo_in, reg_in, alu_ctl, enc_out};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got flags=%b reg_in=%h alu_ctl=%h enc_out=%h, want flags=%b reg_in=%h alu_ctl=%h enc_out=%h",
               nm, act[68:61], act[60:45], act[44:32], act[31:0],
               exp[68:61], exp[60:45], exp[44:32], exp[31:0]);
    end
  endtask

  logic watch = 1'b0;
  logic saw_hilo = 1'b0;
  always @(posedge Clock) if (watch && (hi_in || lo_in)) saw_hilo <= 1'b1;

  initial begin
    // ADD r3 = r1 + r2
    add("add_ta",   1, 4'd0, 4'd1, 4'd2, 4'd3, F_TA,   16'h0000, 13'h0000, 32'h0000_0002);
    add("add_tb",   0, 4'd0, 4'd0, 4'd0, 4'd0, F_TB,   16'h0000, 13'h0040, 32'h0000_0004);
    add("add_twlo", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLO,  16'h0008, 13'h0000, 32'h0008_0000);
    add("add_idle", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // MUL r4 * r5 -> HI/LO
    add("mul_ta",   1, 4'd9, 4'd4, 4'd5, 4'd6, F_TA,   16'h0000, 13'h0000, 32'h0000_0010);
    add("mul_tb",   0, 4'd0, 4'd0, 4'd0, 4'd0, F_TBW,  16'h0000, 13'h1000, 32'h0000_0020);
    add("mul_twlo", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLOW, 16'h0000, 13'h0000, 32'h0008_0000);
    add("mul_twhi", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WHI,  16'h0000, 13'h0000, 32'h0004_0000);
    add("mul_idle", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // NOT r7 -> r7, TA skipped
    add("not_tb",   1, 4'd12, 4'd7, 4'd0, 4'd7, F_TB,  16'h0000, 13'h0001, 32'h0000_0080);
    add("not_twlo", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLO,  16'h0080, 13'h0000, 32'h0008_0000);
    add("not_idle", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // illegal opcode, then ADD r0 = r0 + r15
    add("ill_err",  1, 4'd14, 4'd1, 4'd1, 4'd1, F_ERR, 16'h0000, 13'h0000, 32'h0000_0000);
    add("add2_ta",  1, 4'd0, 4'd0, 4'd15, 4'd0, F_TA,  16'h0000, 13'h0000, 32'h0000_0001);
    add("add2_tb",  0, 4'd0, 4'd0, 4'd0, 4'd0, F_TB,   16'h0000, 13'h0040, 32'h0000_8000);
    add("add2_twlo",0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLO,  16'h0001, 13'h0000, 32'h0008_0000);
    add("add2_idle",0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // NEG r15 -> r0
    add("neg_tb",   1, 4'd11, 4'd15, 4'd3, 4'd0, F_TB, 16'h0000, 13'h0080, 32'h0000_8000);
    add("neg_twlo", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLO,  16'h0001, 13'h0000, 32'h0008_0000);
    add("neg_idle", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // DIV r2 / r3 -> HI/LO
    add("div_ta",   1, 4'd10, 4'd2, 4'd3, 4'd4, F_TA,  16'h0000, 13'h0000, 32'h0000_0004);
    add("div_tb",   0, 4'd0, 4'd0, 4'd0, 4'd0, F_TBW,  16'h0000, 13'h0800, 32'h0000_0008);
    add("div_twlo", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLOW, 16'h0000, 13'h0000, 32'h0008_0000);
    add("div_twhi", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_WHI,  16'h0000, 13'h0000, 32'h0004_0000);
    add("div_idle", 0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    // SUB r5 = r3 - r4 with start held; mid-sequence requests must be ignored
    add("sub1_ta",  1, 4'd1, 4'd3, 4'd4, 4'd5, F_TA,   16'h0000, 13'h0000, 32'h0000_0008);
    add("sub1_tb",  1, 4'd9, 4'd9, 4'd9, 4'd9, F_TB,   16'h0000, 13'h0100, 32'h0000_0010);
    add("sub1_twlo",1, 4'd9, 4'd9, 4'd9, 4'd9, F_WLO,  16'h0020, 13'h0000, 32'h0008_0000);
    add("sub1_idle",1, 4'd1, 4'd3, 4'd4, 4'd5, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    add("sub2_ta",  1, 4'd1, 4'd3, 4'd4, 4'd5, F_TA,   16'h0000, 13'h0000, 32'h0000_0008);
    add("sub2_tb",  0, 4'd0, 4'd0, 4'd0, 4'd0, F_TB,   16'h0000, 13'h0100, 32'h0000_0010);
    add("sub2_twlo",0, 4'd0, 4'd0, 4'd0, 4'd0, F_WLO,  16'h0020, 13'h0000, 32'h0008_0000);
    add("sub2_idle",0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);
    add("sub_nodup",0, 4'd0, 4'd0, 4'd0, 4'd0, F_IDLE, 16'h0000, 13'h0000, 32'h0000_0000);

    Clear = 1'b1; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    #2 chk("reset_async", 69'd0);
    @(posedge Clock); #1 chk("reset_held", 69'd0);
    @(negedge Clock) Clear = 1'b0;
    @(posedge Clock); #1 chk("reset_idle", 69'd0);

    foreach (tbl[i]) begin
      @(negedge Clock);
      start = tbl[i].st; opcode = tbl[i].op; ra = tbl[i].a; rb = tbl[i].b; rc = tbl[i].c;
      @(posedge Clock); #1 chk(tbl[i].name, tbl[i].exp);
    end

    // DIV aborted by Clear during TB
    @(negedge Clock);
    start = 1'b1; opcode = 4'd10; ra = 4'd2; rb = 4'd3; rc = 4'd4; watch = 1'b1;
    @(negedge Clock) start = 1'b0;
    @(posedge Clock); #1 chk("clr_div_tb", {F_TBW, 16'h0000, 13'h0800, 32'h0000_0008});
    #2 Clear = 1'b1;
    #1 chk("clr_immediate", 69'd0);
    @(posedge Clock); #1 chk("clr_held", 69'd0);
    @(negedge Clock) Clear = 1'b0;
    @(posedge Clock); #1 chk("clr_no_resume1", 69'd0);
    @(posedge Clock); #1 chk("clr_no_resume2", 69'd0);
    @(posedge Clock); #1;
    watch = 1'b0;
    checks++;
    if (saw_hilo !== 1'b0) begin
      failures++;
      $display("FAIL clr_hilo_never: got hi/lo seen=%b, want 0", saw_hilo);
    end
    @(negedge Clock);
    start = 1'b1; opcode = 4'd0; ra = 4'd6; rb = 4'd1; rc = 4'd2;
    @(posedge Clock); #1 chk("clr_recover_ta", {F_TA, 16'h0000, 13'h0000, 32'h0000_0040});
    @(negedge Clock) start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
